// File: rtl/wb_burst_mem_slave.sv
// rtl/wb_burst_mem_slave.sv - Wishbone B3 word-memory slave terminating linear line-refill bursts
module wb_burst_mem_slave #(
   parameter int              AW          = 32,
   parameter int              MEM_WORDS   = 1024,
   parameter logic [AW-1:0]   BASE_ADDR   = '0,
   parameter int              WAIT_STATES = 1,
   parameter int              BURST_MAX   = 8
) (
   input  logic          wb_clk_i,
   input  logic          rst,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic          wb_we_i,
   input  logic [AW-1:0] wb_adr_i,
   input  logic [3:0]    wb_sel_i,
   input  logic [31:0]   wb_dat_i,
   input  logic [2:0]    wb_cti_i,
   input  logic [1:0]    wb_bte_i,
   output logic [31:0]   wb_dat_o,
   output logic          wb_ack_o,
   output logic          wb_err_o,
   output logic          wb_rty_o,
   output logic          busy_o
);

   localparam int IW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int BCW = $clog2(BURST_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER} state_t;

   state_t          r_state;
   logic [31:0]     r_mem [MEM_WORDS];
   logic [IW-1:0]   r_widx;
   logic [BCW-1:0]  r_beat;
   logic [3:0]      r_wait;
   logic            r_ack;
   logic            r_err;
   logic [31:0]     r_dat;

   logic [AW-1:0]   w_off;
   logic            w_in_range;
   logic [IW-1:0]   w_start_idx;
   logic            w_bad_bte;
   logic            w_req;
   logic            w_burst;
   logic [IW:0]     w_nidx;
   logic            w_last_word;
   logic [BCW-1:0]  w_beat_n;
   logic            w_beat_max;
   logic            w_mem_we;

   // Window decode relative to the base; only the first beat's address matters.
   assign w_off       = wb_adr_i - BASE_ADDR;
   assign w_in_range  = (w_off >> 2) < AW'(MEM_WORDS);
   assign w_start_idx = w_off[IW+1:2];
   assign w_bad_bte   = (wb_cti_i == 3'b010) && (wb_bte_i != 2'b00);
   assign w_req       = wb_cyc_i & wb_stb_i;
   assign w_burst     = (wb_cti_i == 3'b010);

   // Next-beat bookkeeping: the extra top bit flags running off the end of memory.
   assign w_nidx      = {1'b0, r_widx} + 1'b1;
   assign w_last_word = w_nidx[IW];
   assign w_beat_n    = r_beat + 1'b1;
   assign w_beat_max  = (w_beat_n == BCW'(BURST_MAX));

   // Terminations are only visible while the master is actually strobing.
   assign wb_ack_o = r_ack & w_req;
   assign wb_err_o = r_err & w_req;
   assign wb_rty_o = 1'b0;
   assign wb_dat_o = r_dat;
   assign busy_o   = (r_state != S_IDLE);

   assign w_mem_we = (r_state == S_XFER) & wb_ack_o & wb_we_i & ~rst;

   // Byte-lane writes on every acked write beat; contents survive reset.
   always_ff @(posedge wb_clk_i) begin
      for (int b = 0; b < 4; b++) begin
         if (w_mem_we && wb_sel_i[b]) begin
            r_mem[r_widx][8*b +: 8] <= wb_dat_i[8*b +: 8];
         end
      end
   end

   // Cycle FSM: decode, wait states, then one beat per acked cycle with read-old data.
   always_ff @(posedge wb_clk_i) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_dat   <= 32'd0;
         r_widx  <= '0;
         r_beat  <= '0;
         r_wait  <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_ack <= 1'b0;
               if (r_err) begin
                  // Error lasts one cycle; the master drops the request before retrying.
                  r_err <= 1'b0;
               end else if (w_req) begin
                  if (!w_in_range || w_bad_bte) begin
                     r_err <= 1'b1;
                  end else begin
                     r_widx <= w_start_idx;
                     r_beat <= '0;
                     r_wait <= 4'(WAIT_STATES);
                     if (WAIT_STATES > 0) begin
                        r_state <= S_WAIT;
                     end else begin
                        r_state <= S_XFER;
                        r_ack   <= 1'b1;
                        r_dat   <= r_mem[w_start_idx];
                     end
                  end
               end
            end
            S_WAIT: begin
               if (!wb_cyc_i) begin
                  r_state <= S_IDLE;
               end else begin
                  r_wait <= r_wait - 4'd1;
                  if (r_wait == 4'd1) begin
                     r_state <= S_XFER;
                     r_ack   <= 1'b1;
                     r_dat   <= r_mem[r_widx];
                  end
               end
            end
            S_XFER: begin
               if (!wb_cyc_i) begin
                  r_ack   <= 1'b0;
                  r_err   <= 1'b0;
                  r_state <= S_IDLE;
               end else if (wb_err_o) begin
                  // Errored beat has been presented and seen; abandon the burst.
                  r_err   <= 1'b0;
                  r_state <= S_IDLE;
               end else if (wb_ack_o) begin
                  if (w_burst) begin
                     if (w_last_word || w_beat_max) begin
                        r_ack <= 1'b0;
                        r_err <= 1'b1;
                     end else begin
                        r_widx <= w_nidx[IW-1:0];
                        r_beat <= w_beat_n;
                        r_dat  <= r_mem[w_nidx[IW-1:0]];
                     end
                  end else begin
                     r_ack   <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_ack   <= 1'b0;
               r_err   <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// tb/tb_wb_burst_mem_slave.sv - scoreboard bench for wb_burst_mem_slave
module tb_wb_burst_mem_slave;

   localparam int MW = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc, stb, we;
   logic [31:0] adr, dat;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o, wb_err_o, wb_rty_o, busy_o;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          last_lat;
   int          last_span;
   logic [31:0] sb_q[$];
   logic [31:0] ref_mem [MW];

   always #5 clk = ~clk;

   wb_burst_mem_slave #(
      .AW(32), .MEM_WORDS(MW), .BASE_ADDR(32'h0), .WAIT_STATES(1), .BURST_MAX(8)
   ) dut (
      .wb_clk_i(clk), .rst(rst),
      .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
      .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat),
      .wb_cti_i(cti), .wb_bte_i(bte),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
      .wb_rty_o(wb_rty_o), .busy_o(busy_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_beat(input logic we_v, input logic [31:0] a, input int n, input int i,
                             input logic [3:0] s, input logic [31:0] wbase, input logic [1:0] bt,
                             input int exp_acks);
      int idx;
      cyc = 1'b1;
      stb = 1'b1;
      we  = we_v;
      adr = a + 32'(i * 4);
      sel = s;
      dat = wbase + 32'(i);
      bte = bt;
      cti = (n == 1) ? 3'b000 : ((i < n - 1) ? 3'b010 : 3'b111);
      idx = int'(a >> 2) + i;
      if (!we_v && i < exp_acks) sb_q.push_back((idx < MW) ? ref_mem[idx] : 32'h0);
   endtask

   task automatic bus_xfer(input logic we_v, input logic [31:0] a, input int n, input logic [3:0] s,
                           input logic [31:0] wbase, input logic [1:0] bt, input int exp_acks,
                           input int exp_err, input int stall_at, input int rst_at);
      int acks, errs, cyc_cnt, beat, stall, idx;
      bit done, got_ack;
      logic [31:0] exp_v;
      acks = 0; errs = 0; cyc_cnt = 0; beat = 0; stall = 0; done = 0;
      last_lat = -1; last_span = -1;
      @(posedge clk); #1;
      drive_beat(we_v, a, n, 0, s, wbase, bt, exp_acks);
      while (!done) begin
         if (rst_at >= 0 && acks == rst_at) begin
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("rst_ack", 32'(wb_ack_o), 0);
            check("rst_busy", 32'(busy_o), 0);
            cyc = 1'b0; stb = 1'b0; rst = 1'b0;
            done = 1;
         end else begin
            @(negedge clk);
            got_ack = wb_ack_o;
            check("ack_err_excl", 32'(wb_ack_o & wb_err_o), 0);
            if (!stb) check("stall_noack", 32'(wb_ack_o), 0);
            if (got_ack) begin
               if (last_lat < 0) last_lat = cyc_cnt;
               last_span = cyc_cnt;
               idx = int'(adr >> 2);
               if (!we) begin
                  if (sb_q.size() == 0) check("sb_underflow", 1, 0);
                  else begin
                     exp_v = sb_q.pop_front();
                     check("rdata", wb_dat_o, exp_v);
                  end
               end else begin
                  for (int b = 0; b < 4; b++)
                     if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
               end
               acks++;
            end
            if (wb_err_o) errs++;
            cyc_cnt++;
            if (errs > 0 || acks == n) begin
               @(posedge clk); #1;
               cyc = 1'b0; stb = 1'b0; cti = 3'b000;
               done = 1;
            end else if (cyc_cnt > 80) begin
               check("timeout", 1, 0);
               @(posedge clk); #1;
               cyc = 1'b0; stb = 1'b0;
               done = 1;
            end else begin
               @(posedge clk); #1;
               if (got_ack) begin
                  beat++;
                  if (acks == stall_at) begin
                     stall = 2;
                     stb = 1'b0;
                  end else begin
                     drive_beat(we_v, a, n, beat, s, wbase, bt, exp_acks);
                  end
               end else if (stall > 0) begin
                  stall--;
                  if (stall == 0) drive_beat(we_v, a, n, beat, s, wbase, bt, exp_acks);
               end
            end
         end
      end
      if (rst_at >= 0) begin
         check("rst_acks", acks, rst_at);
      end else begin
         check("acks", acks, exp_acks);
         check("errs", errs, exp_err);
         @(negedge clk);
         check("busy_after", 32'(busy_o), 0);
      end
   endtask

   initial begin
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      adr = 32'h0; dat = 32'h0; sel = 4'h0; cti = 3'b000; bte = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ack", 32'(wb_ack_o), 0);
      check("rst_err", 32'(wb_err_o), 0);
      check("rst_dat", wb_dat_o, 32'h0);
      check("rst_busy", 32'(busy_o), 0);
      check("rty", 32'(wb_rty_o), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Classic write then read with one wait state
      bus_xfer(1'b1, 32'h10, 1, 4'hF, 32'hDEADBEEF, 2'b00, 1, 0, -1, -1);
      check("wr_latency", last_lat, 2);
      bus_xfer(1'b0, 32'h10, 1, 4'hF, 32'h0, 2'b00, 1, 0, -1, -1);
      check("rd_latency", last_lat, 2);
      check("rd_deadbeef", wb_dat_o, 32'hDEADBEEF);

      // Partial byte selects and an all-zero select
      bus_xfer(1'b1, 32'h10, 1, 4'b0101, 32'h11223344, 2'b00, 1, 0, -1, -1);
      bus_xfer(1'b0, 32'h10, 1, 4'hF, 32'h0, 2'b00, 1, 0, -1, -1);
      bus_xfer(1'b1, 32'h10, 1, 4'b0000, 32'hFFFFFFFF, 2'b00, 1, 0, -1, -1);
      bus_xfer(1'b0, 32'h10, 1, 4'hF, 32'h0, 2'b00, 1, 0, -1, -1);

      // Word 0 sentinel used later to prove the end-of-memory burst does not wrap
      bus_xfer(1'b1, 32'h0, 1, 4'hF, 32'hA5A50000, 2'b00, 1, 0, -1, -1);

      // Preload the line with a write burst, then refill it with a read burst
      bus_xfer(1'b1, 32'h20, 8, 4'hF, 32'h100, 2'b00, 8, 0, -1, -1);
      check("wburst_span", last_span, 9);
      bus_xfer(1'b0, 32'h20, 8, 4'hF, 32'h0, 2'b00, 8, 0, -1, -1);
      check("rburst_span", last_span, 9);

      // Master stall after the fourth beat
      bus_xfer(1'b0, 32'h20, 8, 4'hF, 32'h0, 2'b00, 8, 0, 4, -1);
      check("stall_span", last_span, 11);

      // Out-of-window address and unsupported burst type
      bus_xfer(1'b0, 32'(MW * 4), 1, 4'hF, 32'h0, 2'b00, 0, 1, -1, -1);
      bus_xfer(1'b0, 32'h20, 4, 4'hF, 32'h0, 2'b01, 0, 1, -1, -1);

      // Write burst running off the end of memory
      bus_xfer(1'b1, 32'((MW - 2) * 4), 3, 4'hF, 32'h200, 2'b00, 2, 1, -1, -1);
      bus_xfer(1'b0, 32'((MW - 2) * 4), 2, 4'hF, 32'h0, 2'b00, 2, 0, -1, -1);
      bus_xfer(1'b0, 32'h0, 1, 4'hF, 32'h0, 2'b00, 1, 0, -1, -1);
      check("no_wrap", wb_dat_o, 32'hA5A50000);

      // Burst longer than the beat limit
      bus_xfer(1'b0, 32'h20, 9, 4'hF, 32'h0, 2'b00, 8, 1, -1, -1);

      // Reset during beat 5, then a classic read
      bus_xfer(1'b0, 32'h20, 8, 4'hF, 32'h0, 2'b00, 5, 0, -1, 5);
      bus_xfer(1'b0, 32'h24, 1, 4'hF, 32'h0, 2'b00, 1, 0, -1, -1);
      check("post_rst_read", wb_dat_o, 32'h101);

      check("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
